// File: rtl/tcb_trigger_scheduler.sv
// tcb_trigger_scheduler: serializes peripheral trigger events into monitored TCB invocations
module tcb_trigger_scheduler #(
   parameter logic [15:0] TCB_BASE   = 16'hFAE0,
   parameter logic [15:0] TCB_SIZE   = 16'h03FC,
   parameter int          N_SRC      = 3,
   parameter logic [15:0] ENTRY_WAIT = 16'd64,
   parameter logic [15:0] RUN_BUDGET = 16'h4000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      pc,
   input  logic [N_SRC-1:0] trig_req,
   input  logic             irq_ack,
   output logic             tcb_irq,
   output logic [1:0]       tcb_src,
   output logic             busy,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] overrun,
   output logic             reset
);
   typedef enum logic [1:0] {IDLE, REQ, ENTER, RUN} state_t;
   state_t state, state_n;
   logic [N_SRC-1:0] trig_q, ev, gmask;
   logic [1:0] last_src, gsrc, sel_lo, sel_hi;
   logic has_hi, grant, in_tcb, viol, run_start;
   logic [15:0] cnt;
   assign ev = trig_req & ~trig_q;
   assign in_tcb = {1'b0, pc} >= {1'b0, TCB_BASE} && {1'b0, pc} <= {1'b0, TCB_BASE} + {1'b0, TCB_SIZE};
   assign grant = state == IDLE && |pending;
   assign gmask = grant ? N_SRC'(1) << gsrc : '0;
   assign viol = ((state == REQ || state == ENTER) && cnt == ENTRY_WAIT)
              || (state == ENTER && in_tcb && pc != TCB_BASE)
              || (state == RUN && cnt == RUN_BUDGET);
   assign run_start = state == ENTER && state_n == RUN;
   // round-robin pick: lowest pending source above last_src, else lowest pending overall
   always_comb begin
      sel_lo = '0;
      sel_hi = '0;
      has_hi = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (pending[i]) sel_lo = 2'(i);
         if (pending[i] && i > int'(last_src)) begin
            sel_hi = 2'(i);
            has_hi = 1'b1;
         end
      end
      gsrc = has_hi ? sel_hi : sel_lo;
   end
   // state register
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   // next-state: any violation returns to IDLE ahead of normal progress
   always_comb begin
      case (state)
         IDLE:    state_n = grant ? REQ : IDLE;
         REQ:     state_n = viol ? IDLE : irq_ack ? ENTER : REQ;
         ENTER:   state_n = viol ? IDLE : in_tcb ? RUN : ENTER;
         RUN:     state_n = viol || !in_tcb ? IDLE : RUN;
         default: state_n = IDLE;
      endcase
   end
   // outputs decoded from state
   always_comb begin
      tcb_irq = state == REQ;
      busy = state != IDLE;
   end
   // event latching, grant bookkeeping, saturating phase counter and violation pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trig_q   <= '0;
         pending  <= '0;
         overrun  <= '0;
         last_src <= 2'(N_SRC - 1);
         tcb_src  <= '0;
         cnt      <= '0;
         reset    <= 1'b0;
      end else begin
         trig_q  <= trig_req;
         reset   <= viol;
         overrun <= overrun | (ev & pending & ~gmask);
         pending <= viol ? '0 : (pending & ~gmask) | ev;
         if (grant) begin
            tcb_src  <= gsrc;
            last_src <= gsrc;
         end
         cnt <= grant || run_start ? '0 : state != IDLE && cnt != '1 ? cnt + 16'd1 : cnt;
      end
   end
endmodule

// File: tb/tb_tcb_trigger_scheduler.sv
// tb_tcb_trigger_scheduler: scenario tasks plus randomized round-robin checks against a queue-free arithmetic model
module tb_tcb_trigger_scheduler;
   localparam int N = 3;
   localparam logic [15:0] BASE = 16'hFAE0;
   localparam logic [15:0] OUTPC = 16'hE000;
   localparam logic [15:0] EXITPC = 16'hE100;
   localparam int EW = 64;
   localparam int RB = 16'h4000;
   logic clk, rst_n, irq_ack, tcb_irq, busy, reset;
   logic [15:0] pc;
   logic [N-1:0] trig_req, pending, overrun;
   logic [1:0] tcb_src;
   int vec, errs, rst_pulses;

   tcb_trigger_scheduler dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .trig_req(trig_req), .irq_ack(irq_ack),
      .tcb_irq(tcb_irq), .tcb_src(tcb_src), .busy(busy), .pending(pending),
      .overrun(overrun), .reset(reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (reset === 1'b1) rst_pulses++;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", vec);
      $fatal(1);
   end

   function automatic int next_grant(input logic [2:0] p, input int last);
      int idx;
      for (int k = 1; k <= N; k++) begin
         idx = (last + k) % N;
         if (((p >> idx) & 3'b001) != 3'b000) return idx;
      end
      return -1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut;
      rst_n = 1'b0; trig_req = '0; irq_ack = 1'b0; pc = OUTPC;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_irq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (tcb_irq === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic serve(input int d, input int r, input int inj_at, input int inj_src);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      repeat (d) tick();
      pc = BASE;
      for (int c = 0; c < r; c++) begin
         trig_req = (c == inj_at) ? 3'(1) << inj_src : 3'b000;
         tick();
      end
      trig_req = '0;
      pc = EXITPC;
      tick();
      pc = OUTPC;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; trig_req = '0; irq_ack = 1'b0; pc = OUTPC;
      tick(); tick();
      vec++;
      if ({tcb_irq, tcb_src, busy, pending, overrun, reset} !== 11'd0) begin
         errs++; $display("FAIL reset_outputs: got %b want 0", {tcb_irq, tcb_src, busy, pending, overrun, reset});
      end
      rst_n = 1'b1;
      tick();
      vec++;
      if (busy !== 1'b0 || pending !== 3'b000) begin
         errs++; $display("FAIL reset_idle: busy %b pending %b want 0 000", busy, pending);
      end
   endtask

   task automatic test_single;
      trig_req = 3'b010;
      tick();
      trig_req = '0;
      vec++;
      if (pending !== 3'b010 || tcb_irq !== 1'b0) begin
         errs++; $display("FAIL single_pending: pending %b irq %b want 010 0", pending, tcb_irq);
      end
      tick();
      vec++;
      if ({tcb_irq, busy, tcb_src, pending} !== {1'b1, 1'b1, 2'd1, 3'b000}) begin
         errs++; $display("FAIL single_grant: irq %b busy %b src %0d pending %b want 1 1 1 000", tcb_irq, busy, tcb_src, pending);
      end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      vec++;
      if (tcb_irq !== 1'b0 || busy !== 1'b1) begin
         errs++; $display("FAIL single_ack: irq %b busy %b want 0 1", tcb_irq, busy);
      end
      pc = BASE;
      repeat (10) tick();
      vec++;
      if (busy !== 1'b1 || reset !== 1'b0) begin
         errs++; $display("FAIL single_run: busy %b reset %b want 1 0", busy, reset);
      end
      pc = EXITPC;
      tick();
      pc = OUTPC;
      vec++;
      if (busy !== 1'b0) begin
         errs++; $display("FAIL single_exit: busy %b want 0", busy);
      end
      vec++;
      if (rst_pulses !== 0) begin
         errs++; $display("FAIL single_noreset: pulses %0d want 0", rst_pulses);
      end
   endtask

   task automatic test_round_robin;
      logic [2:0] pend;
      int last, g;
      bit ok;
      reset_dut();
      last = N - 1;
      for (int pass = 0; pass < 2; pass++) begin
         trig_req = 3'b111;
         tick();
         trig_req = '0;
         pend = 3'b111;
         vec++;
         if (pending !== pend) begin
            errs++; $display("FAIL rr_pending: got %b want %b", pending, pend);
         end
         for (int n = 0; n < N; n++) begin
            wait_irq(ok);
            vec++;
            if (!ok) begin
               errs++; $display("FAIL rr_wait: got no irq want irq");
            end
            g = next_grant(pend, last);
            vec++;
            if (tcb_src !== 2'(g)) begin
               errs++; $display("FAIL rr_order: got %0d want %0d", tcb_src, g);
            end
            pend = pend & ~(3'(1) << g);
            last = g;
            serve(1, 3, -1, 0);
            vec++;
            if (busy !== 1'b0) begin
               errs++; $display("FAIL rr_idle_gap: busy %b want 0", busy);
            end
         end
      end
   endtask

   task automatic test_overrun;
      bit ok;
      trig_req = 3'b001;
      tick();
      trig_req = '0;
      wait_irq(ok);
      vec++;
      if (!ok || tcb_src !== 2'd0) begin
         errs++; $display("FAIL ovr_grant0: ok %b src %0d want 1 0", ok, tcb_src);
      end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      pc = BASE;
      tick();
      trig_req = 3'b100; tick();
      trig_req = 3'b000; tick();
      trig_req = 3'b100; tick();
      trig_req = 3'b000; tick();
      vec++;
      if (overrun !== 3'b100 || pending !== 3'b100) begin
         errs++; $display("FAIL ovr_flags: overrun %b pending %b want 100 100", overrun, pending);
      end
      pc = EXITPC;
      tick();
      pc = OUTPC;
      wait_irq(ok);
      vec++;
      if (!ok || tcb_src !== 2'd2) begin
         errs++; $display("FAIL ovr_grant2: ok %b src %0d want 1 2", ok, tcb_src);
      end
      serve(0, 2, -1, 0);
      repeat (3) tick();
      vec++;
      if (pending !== 3'b000 || busy !== 1'b0 || overrun !== 3'b100) begin
         errs++; $display("FAIL ovr_once: pending %b busy %b overrun %b want 000 0 100", pending, busy, overrun);
      end
   endtask

   task automatic test_bad_entry;
      bit ok;
      int p0;
      trig_req = 3'b010;
      tick();
      trig_req = '0;
      wait_irq(ok);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      trig_req = 3'b001;
      tick();
      trig_req = '0;
      vec++;
      if (!ok || pending !== 3'b001) begin
         errs++; $display("FAIL bad_setup: ok %b pending %b want 1 001", ok, pending);
      end
      p0 = rst_pulses;
      pc = BASE + 16'd4;
      tick();
      vec++;
      if ({reset, busy, tcb_irq, pending} !== {1'b1, 1'b0, 1'b0, 3'b000}) begin
         errs++; $display("FAIL bad_entry: reset %b busy %b irq %b pending %b want 1 0 0 000", reset, busy, tcb_irq, pending);
      end
      pc = OUTPC;
      tick();
      vec++;
      if (reset !== 1'b0 || rst_pulses !== p0 + 1) begin
         errs++; $display("FAIL bad_pulse: reset %b pulses %0d want 0 %0d", reset, rst_pulses, p0 + 1);
      end
      vec++;
      if (overrun !== 3'b100) begin
         errs++; $display("FAIL bad_keep_overrun: got %b want 100", overrun);
      end
   endtask

   task automatic test_entry_timeout;
      bit ok;
      int n;
      trig_req = 3'b001;
      tick();
      trig_req = '0;
      wait_irq(ok);
      n = 0;
      while (reset !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      vec++;
      if (!ok || n != EW + 1) begin
         errs++; $display("FAIL entry_timeout: cycles %0d want %0d", n, EW + 1);
      end
      vec++;
      if (busy !== 1'b0) begin
         errs++; $display("FAIL entry_timeout_idle: busy %b want 0", busy);
      end
      tick();
   endtask

   task automatic test_run_timeout;
      bit ok;
      int n;
      trig_req = 3'b010;
      tick();
      trig_req = '0;
      wait_irq(ok);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      pc = BASE;
      tick();
      n = 0;
      while (reset !== 1'b1 && n < RB + 100) begin
         tick();
         n++;
      end
      vec++;
      if (!ok || n != RB + 1) begin
         errs++; $display("FAIL run_timeout: cycles %0d want %0d", n, RB + 1);
      end
      vec++;
      if (busy !== 1'b0) begin
         errs++; $display("FAIL run_timeout_idle: busy %b want 0", busy);
      end
      pc = OUTPC;
      tick();
   endtask

   task automatic test_reset_mid_run;
      bit ok;
      int p0;
      trig_req = 3'b100;
      tick();
      trig_req = '0;
      wait_irq(ok);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      pc = BASE;
      repeat (4) tick();
      p0 = rst_pulses;
      rst_n = 1'b0;
      trig_req = 3'b001;
      tick();
      vec++;
      if ({tcb_irq, tcb_src, busy, pending, overrun, reset} !== 11'd0) begin
         errs++; $display("FAIL midrun_reset: got %b want 0", {tcb_irq, tcb_src, busy, pending, overrun, reset});
      end
      rst_n = 1'b1;
      pc = OUTPC;
      tick();
      vec++;
      if (pending !== 3'b001 || reset !== 1'b0) begin
         errs++; $display("FAIL midrun_level_event: pending %b reset %b want 001 0", pending, reset);
      end
      tick();
      vec++;
      if (tcb_irq !== 1'b1 || tcb_src !== 2'd0) begin
         errs++; $display("FAIL midrun_regrant: irq %b src %0d want 1 0", tcb_irq, tcb_src);
      end
      trig_req = '0;
      serve(0, 2, -1, 0);
      tick();
      vec++;
      if (rst_pulses !== p0 || !ok) begin
         errs++; $display("FAIL midrun_nopulse: pulses %0d ok %b want %0d 1", rst_pulses, ok, p0);
      end
   endtask

   task automatic test_random;
      logic [2:0] pend, ovr, m, bit_s;
      int last, g, r, j, s, guard;
      bit ok;
      reset_dut();
      pend = '0; ovr = '0; last = N - 1;
      for (int round = 0; round < 12; round++) begin
         m = 3'($urandom_range(1, 7));
         trig_req = m;
         tick();
         trig_req = '0;
         pend = pend | m;
         guard = 0;
         while (pend != 3'b000 && guard < 20) begin
            guard++;
            wait_irq(ok);
            vec++;
            if (!ok) begin
               errs++; $display("FAIL rnd_wait: got no irq want irq, round %0d", round);
            end
            g = next_grant(pend, last);
            vec++;
            if (tcb_src !== 2'(g)) begin
               errs++; $display("FAIL rnd_order: got %0d want %0d, round %0d", tcb_src, g, round);
            end
            pend = pend & ~(3'(1) << g);
            last = g;
            r = $urandom_range(2, 12);
            j = $urandom_range(1, r - 1);
            s = $urandom_range(0, N - 1);
            if ($urandom_range(0, 1) == 0) j = -1;
            else begin
               bit_s = 3'(1) << s;
               if ((pend & bit_s) != 3'b000) ovr = ovr | bit_s;
               pend = pend | bit_s;
            end
            serve($urandom_range(0, 20), r, j, s);
            vec++;
            if (pending !== pend || overrun !== ovr) begin
               errs++; $display("FAIL rnd_flags: pending %b overrun %b want %b %b", pending, overrun, pend, ovr);
            end
         end
      end
      vec++;
      if (busy !== 1'b0 || reset !== 1'b0) begin
         errs++; $display("FAIL rnd_end: busy %b reset %b want 0 0", busy, reset);
      end
   endtask

   initial begin
      vec = 0; errs = 0; rst_pulses = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_overrun();
      test_bad_entry();
      test_entry_timeout();
      test_run_timeout();
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
